// File: rtl/uart_rx_frame_ctrl_if.sv
// Handshake and status bundle between the UART byte receiver, the frame
// controller and the downstream payload sink.
//   master : the frame controller (consumes receiver bytes, drives the stream)
//   slave  : the environment (byte receiver plus payload sink)
interface uart_rx_frame_ctrl_if;
    // Byte receiver side
    logic       Rx_Done_Sig;
    logic [7:0] Rx_Data;
    logic       Rx_En_Sig;

    // Payload stream side
    logic [7:0] Out_Data;
    logic       Out_Valid;
    logic       Out_Ready;
    logic       Out_Last;

    // Frame status
    logic       Frame_Err;
    logic [1:0] Err_Code;
    logic [7:0] Frame_Cnt;

    modport master (
        input  Rx_Done_Sig,
        input  Rx_Data,
        input  Out_Ready,
        output Rx_En_Sig,
        output Out_Data,
        output Out_Valid,
        output Out_Last,
        output Frame_Err,
        output Err_Code,
        output Frame_Cnt
    );

    modport slave (
        output Rx_Done_Sig,
        output Rx_Data,
        output Out_Ready,
        input  Rx_En_Sig,
        input  Out_Data,
        input  Out_Valid,
        input  Out_Last,
        input  Frame_Err,
        input  Err_Code,
        input  Frame_Cnt
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Collects bytes from the UART byte receiver and assembles frames of the form
// [HEADER, LEN, payload x LEN, CSUM]. LEN is range-checked, the checksum is the
// XOR of LEN and every payload byte, and the gap between bytes inside a frame is
// bounded by TIMEOUT_CYC. A good payload is replayed from a local buffer over a
// valid/ready stream while the byte receiver is held off; a bad frame produces
// a one-cycle Frame_Err pulse with a sticky Err_Code.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] HEADER      = 8'h55,
    parameter int         MAX_LEN     = 16,      // 1..255, also the buffer depth
    parameter int         TIMEOUT_CYC = 100000,  // cycles allowed between bytes
    parameter int         CNT_W       = 17       // 2**CNT_W must exceed TIMEOUT_CYC
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_rx_frame_ctrl_if.master bus
);

    // Buffer address width; a single-entry buffer still needs one address bit.
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Counter value at which a silent cycle turns into a timeout error.
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN,
        S_ERR
    } state_t;

    state_t            state_reg;
    logic [7:0]        len_reg;
    logic [7:0]        csum_reg;
    logic [7:0]        idx_reg;
    logic [7:0]        rd_reg;
    logic [CNT_W-1:0]  to_cnt_reg;
    logic              rx_en_reg;
    logic              out_valid_reg;
    logic              out_last_reg;
    logic              frame_err_reg;
    logic [1:0]        err_code_reg;
    logic [7:0]        frame_cnt_reg;
    logic [7:0]        out_data_reg;

    // Payload buffer; written while receiving, read back while draining.
    logic [7:0]        payload_mem [0:MAX_LEN-1];

    logic              byte_ev;
    logic              handshake;
    logic              csum_ok;
    logic              to_expired;
    logic              rd_en;
    logic [7:0]        rd_addr_next;

    // A byte only counts while the receiver is enabled.
    assign byte_ev    = bus.Rx_Done_Sig & rx_en_reg;
    assign handshake  = out_valid_reg & bus.Out_Ready;
    assign csum_ok    = (state_reg == S_CSUM) && byte_ev && (bus.Rx_Data == csum_reg);
    assign to_expired = (to_cnt_reg == TO_LAST);

    // Read pointer for the next cycle: restart at 0 on a good checksum, step on
    // each non-final handshake, otherwise hold so stalled data stays put.
    always_comb begin
        rd_addr_next = rd_reg;
        if (csum_ok) begin
            rd_addr_next = 8'd0;
        end else if ((state_reg == S_DRAIN) && handshake && !out_last_reg) begin
            rd_addr_next = rd_reg + 8'd1;
        end
    end

    // The output register is refreshed when entering DRAIN and every DRAIN cycle
    // except the one that completes the frame.
    assign rd_en = csum_ok || ((state_reg == S_DRAIN) && !(handshake && out_last_reg));

    // Buffer write port: one payload byte per byte event in PAYLOAD.
    always_ff @(posedge CLK) begin
        if ((state_reg == S_PAYLOAD) && byte_ev) begin
            payload_mem[idx_reg[IDX_W-1:0]] <= bus.Rx_Data;
        end
    end

    // Buffer registered read port; prefetching via rd_addr_next makes the first
    // byte visible in the cycle right after the checksum byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_data_reg <= 8'h00;
        end else if (rd_en) begin
            out_data_reg <= payload_mem[rd_addr_next[IDX_W-1:0]];
        end
    end

    // Frame sequencing FSM with all status outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            len_reg       <= 8'd0;
            csum_reg      <= 8'd0;
            idx_reg       <= 8'd0;
            rd_reg        <= 8'd0;
            to_cnt_reg    <= '0;
            rx_en_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= 2'd0;
            frame_cnt_reg <= 8'd0;
        end else begin
            frame_err_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    // Hunt for the header; anything else is dropped.
                    rx_en_reg  <= 1'b1;
                    to_cnt_reg <= '0;
                    if (byte_ev && (bus.Rx_Data == HEADER)) begin
                        state_reg <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (byte_ev) begin
                        to_cnt_reg <= '0;
                        if ((bus.Rx_Data == 8'd0) || (bus.Rx_Data > MAX_LEN_B)) begin
                            state_reg     <= S_ERR;
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LEN;
                        end else begin
                            len_reg   <= bus.Rx_Data;
                            csum_reg  <= bus.Rx_Data;
                            idx_reg   <= 8'd0;
                            state_reg <= S_PAYLOAD;
                        end
                    end else if (to_expired) begin
                        state_reg     <= S_ERR;
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TIMEOUT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                S_PAYLOAD: begin
                    if (byte_ev) begin
                        to_cnt_reg <= '0;
                        csum_reg   <= csum_reg ^ bus.Rx_Data;
                        idx_reg    <= idx_reg + 8'd1;
                        if (idx_reg == len_reg - 8'd1) begin
                            state_reg <= S_CSUM;
                        end
                    end else if (to_expired) begin
                        state_reg     <= S_ERR;
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TIMEOUT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                S_CSUM: begin
                    if (byte_ev) begin
                        to_cnt_reg <= '0;
                        if (csum_ok) begin
                            // Hold the receiver off while the buffer is replayed.
                            state_reg     <= S_DRAIN;
                            rx_en_reg     <= 1'b0;
                            out_valid_reg <= 1'b1;
                            rd_reg        <= rd_addr_next;
                            out_last_reg  <= (len_reg == 8'd1);
                        end else begin
                            state_reg     <= S_ERR;
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_CSUM;
                        end
                    end else if (to_expired) begin
                        state_reg     <= S_ERR;
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TIMEOUT;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
                end

                S_DRAIN: begin
                    to_cnt_reg <= '0;
                    if (handshake) begin
                        if (out_last_reg) begin
                            // Final byte accepted: count the frame and re-arm the receiver.
                            state_reg     <= S_IDLE;
                            rx_en_reg     <= 1'b1;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end else begin
                            rd_reg       <= rd_addr_next;
                            out_last_reg <= (rd_addr_next == len_reg - 8'd1);
                        end
                    end
                end

                S_ERR: begin
                    // Frame_Err was raised on entry; it drops as we leave.
                    to_cnt_reg <= '0;
                    state_reg  <= S_IDLE;
                end

                default: begin
                    state_reg     <= S_IDLE;
                    rx_en_reg     <= 1'b1;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Rx_En_Sig = rx_en_reg;
    assign bus.Out_Data  = out_data_reg;
    assign bus.Out_Valid = out_valid_reg;
    assign bus.Out_Last  = out_last_reg;
    assign bus.Frame_Err = frame_err_reg;
    assign bus.Err_Code  = err_code_reg;
    assign bus.Frame_Cnt = frame_cnt_reg;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames push their expected
// payload / error codes into queues, and an independent monitor pops and
// compares whenever the DUT presents a payload byte or an error pulse.
module tb_uart_rx_frame_ctrl;

    localparam int T = 20;  // short timeout for simulation

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    uart_rx_frame_ctrl_if bus_if ();

    uart_rx_frame_ctrl #(
        .HEADER      (8'h55),
        .MAX_LEN     (16),
        .TIMEOUT_CYC (T),
        .CNT_W       (5)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q [$];   // {last, data}
    logic [1:0] err_q [$];
    logic [7:0] tx_q  [$];
    logic       stall_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Sink ready: always 1, or toggling every cycle in stall mode.
    initial begin
        bus_if.Out_Ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            bus_if.Out_Ready = stall_mode ? ~bus_if.Out_Ready : 1'b1;
        end
    end

    // Monitor: compare every presented payload byte and every error pulse.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus_if.Out_Valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected got data=%02h last=%0b required no output",
                             bus_if.Out_Data, bus_if.Out_Last);
                end else begin
                    if ({bus_if.Out_Last, bus_if.Out_Data} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL out_byte got=%03h required=%03h",
                                 {bus_if.Out_Last, bus_if.Out_Data}, exp_q[0]);
                    end
                    if (bus_if.Out_Ready) begin
                        $display("out byte %02h last=%0b", bus_if.Out_Data, bus_if.Out_Last);
                        void'(exp_q.pop_front());
                    end
                end
                checks++;
                if (bus_if.Rx_En_Sig !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_en_in_drain got=%b required=0", bus_if.Rx_En_Sig);
                end
            end
            if (bus_if.Frame_Err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected got code=%0d required no error", bus_if.Err_Code);
                end else begin
                    if (bus_if.Err_Code !== err_q[0]) begin
                        errors++;
                        $display("FAIL err_code got=%0d required=%0d", bus_if.Err_Code, err_q[0]);
                    end else begin
                        $display("frame error code %0d", bus_if.Err_Code);
                    end
                    void'(err_q.pop_front());
                end
            end
        end
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        bus_if.Rx_Done_Sig = 1'b1;
        bus_if.Rx_Data     = b;
        @(posedge CLK);
        #1;
        bus_if.Rx_Done_Sig = 1'b0;
        bus_if.Rx_Data     = 8'h00;
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Wait until the scoreboard is empty and the receiver is re-enabled.
    task automatic wait_done(input string name, output int k);
        k = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || bus_if.Rx_En_Sig !== 1'b1) && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL %s_timeout got pending=%0d required 0", name, exp_q.size() + err_q.size());
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rx_en"},  32'(bus_if.Rx_En_Sig), 0);
        chk({name, "_valid"},  32'(bus_if.Out_Valid), 0);
        chk({name, "_last"},   32'(bus_if.Out_Last),  0);
        chk({name, "_data"},   32'(bus_if.Out_Data),  0);
        chk({name, "_ferr"},   32'(bus_if.Frame_Err), 0);
        chk({name, "_code"},   32'(bus_if.Err_Code),  0);
        chk({name, "_cnt"},    32'(bus_if.Frame_Cnt), 0);
    endtask

    initial begin
        int k;
        bus_if.Rx_Done_Sig = 1'b0;
        bus_if.Rx_Data     = 8'h00;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(1);
        chk("rx_en_after_release", 32'(bus_if.Rx_En_Sig), 1);

        // 1: basic frame, sink always ready
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        tx_q = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_all();
        wait_done("t1", k);
        chk("t1_drain_cycles", 32'(k), 3);
        chk("t1_frame_cnt", 32'(bus_if.Frame_Cnt), 1);

        // 2: same frame with a stalling sink
        stall_mode = 1'b1;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        tx_q = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_all();
        wait_done("t2", k);
        stall_mode = 1'b0;
        idle(1);
        chk("t2_frame_cnt", 32'(bus_if.Frame_Cnt), 2);

        // 3: checksum error
        err_q.push_back(2'd2);
        tx_q = '{8'h55, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        send_all();
        wait_done("t3", k);
        chk("t3_frame_cnt", 32'(bus_if.Frame_Cnt), 2);
        chk("t3_err_code", 32'(bus_if.Err_Code), 2);

        // 4: bad lengths, then a junk byte before a 1-byte frame
        err_q.push_back(2'd1);
        tx_q = '{8'h55, 8'h00};
        send_all();
        wait_done("t4a", k);
        err_q.push_back(2'd1);
        tx_q = '{8'h55, 8'h11};
        send_all();
        wait_done("t4b", k);
        exp_q.push_back({1'b1, 8'h7E});
        tx_q = '{8'hAA, 8'h55, 8'h01, 8'h7E, 8'h7F};
        send_all();
        wait_done("t4c", k);
        chk("t4_frame_cnt", 32'(bus_if.Frame_Cnt), 3);
        chk("t4_err_code_held", 32'(bus_if.Err_Code), 1);

        // 5a: byte arriving on the exact timeout cycle is accepted
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        tx_q = '{8'h55, 8'h02, 8'h10};
        send_all();
        idle(T - 1);
        tx_q = '{8'h20, 8'h32};
        send_all();
        wait_done("t5a", k);
        chk("t5a_frame_cnt", 32'(bus_if.Frame_Cnt), 4);

        // 5b: silence for the full timeout
        err_q.push_back(2'd3);
        tx_q = '{8'h55, 8'h02, 8'h10};
        send_all();
        wait_done("t5b", k);
        chk("t5b_err_cycle", 32'(k), T + 1);
        chk("t5b_err_code", 32'(bus_if.Err_Code), 3);

        // 6: reset in the middle of a payload, then a good frame
        tx_q = '{8'h55, 8'h03, 8'h11};
        send_all();
        RST = 1'b1;
        @(negedge CLK);
        chk_all_zero("midreset");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(1);
        exp_q.push_back({1'b1, 8'hA5});
        tx_q = '{8'h55, 8'h01, 8'hA5, 8'hA4};
        send_all();
        wait_done("t6", k);
        chk("t6_frame_cnt", 32'(bus_if.Frame_Cnt), 1);

        idle(3);
        chk("final_exp_empty", 32'(exp_q.size()), 0);
        chk("final_err_empty", 32'(err_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #500000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
